// File: rtl/cache_mem_responder_if.sv
// Cache-to-memory bus: instruction and data requesters on one side, single-ported RAM on the
// other, all seen from the responder in the middle.
interface cache_mem_responder_if;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic        dwait;
  logic [31:0] dload;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  logic [1:0]  ramstate;
  logic        err;

  modport responder (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, err
  );

  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, err
  );
endinterface

// File: rtl/cache_mem_responder.sv
// Arbitrates instruction and data caches onto one variable-latency RAM, with starvation guard,
// RAM-error abort and stall timeout.
module cache_mem_responder #(
  parameter int unsigned TIMEOUT      = 64,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input logic                       CLK,
  input logic                       RST,
  cache_mem_responder_if.responder  bus
);

  localparam int unsigned CntW    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned StarveW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CntW-1:0]    CntLast   = CntW'(TIMEOUT - 1);
  localparam logic [StarveW-1:0] StarveMax = StarveW'(STARVE_LIMIT);
  localparam logic [1:0] RamAccess = 2'd2;
  localparam logic [1:0] RamError  = 2'd3;

  typedef enum logic [1:0] {StIdle, StIfetch, StDread, StDwrite} state_e;

  state_e              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [StarveW-1:0]  starve_q, starve_d;
  logic                held, done, err_c;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    starve_d = starve_q;
    held     = 1'b0;
    done     = 1'b0;
    err_c    = 1'b0;
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (bus.iREN && starve_q == StarveMax) begin
          state_d  = StIfetch;
          starve_d = '0;
        end else if (bus.dWEN || bus.dREN) begin
          // Write wins when both data strobes are high.
          state_d = bus.dWEN ? StDwrite : StDread;
          if (!bus.iREN)                starve_d = '0;
          else if (starve_q != StarveMax) starve_d = starve_q + 1'b1;
        end else if (bus.iREN) begin
          state_d  = StIfetch;
          starve_d = '0;
        end
      end
      StIfetch: held = bus.iREN;
      StDread:  held = bus.dREN;
      StDwrite: held = bus.dWEN;
      default:  held = 1'b0;
    endcase

    if (state_q != StIdle) begin
      if (!held) begin
        state_d = StIdle;
      end else if (bus.ramstate == RamAccess) begin
        done    = 1'b1;
        state_d = StIdle;
      end else if (bus.ramstate == RamError || cnt_q == CntLast) begin
        err_c   = 1'b1;
        state_d = StIdle;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
      if (state_d == StIdle) cnt_d = '0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      starve_q <= starve_d;
    end
  end

  // Address and write data follow the requester live; completion is combinational on ACCESS.
  always_comb begin
    bus.ramREN   = (state_q == StIfetch) || (state_q == StDread);
    bus.ramWEN   = (state_q == StDwrite);
    bus.ramaddr  = (state_q == StIfetch) ? bus.iaddr :
                   (state_q == StIdle)   ? 32'h0     : bus.daddr;
    bus.ramstore = (state_q == StDwrite) ? bus.dstore : 32'h0;
    bus.iwait    = !(done && state_q == StIfetch);
    bus.iload    = (done && state_q == StIfetch) ? bus.ramload : 32'h0;
    bus.dwait    = !(done && (state_q == StDread || state_q == StDwrite));
    bus.dload    = (done && state_q == StDread) ? bus.ramload : 32'h0;
    bus.err      = err_c;
  end

endmodule

// File: doc/cache_mem_responder.md
Name: cache_mem_responder

Overview:
- Responder end of the cache-to-memory interface (iREN/iaddr/iwait/iload, dREN/dWEN/daddr/dstore/dwait/dload).
- Serves one instruction-cache requester and one data-cache requester against a single-ported RAM with variable latency.
- Arbitrates between the two requesters, sequences each RAM access, and drives the per-requester wait/load signals.
- Detects RAM errors and stalled accesses.

Parameters:
- TIMEOUT, 64: cycles an access may stay outstanding without ramstate==ACCESS before it is aborted (must be >=2).
- STARVE_LIMIT, 4: consecutive data grants allowed while iREN is pending before instruction is forced.

Ports:
- CLK  in  1  clock, all state on rising edge
- RST  in  1  synchronous active-high reset
- iREN  in  1  instruction read request
- iaddr  in  32  instruction word address
- iwait  out  1  0 only in the cycle the instruction read completes
- iload  out  32  instruction data, valid when iwait==0
- dREN  in  1  data read request
- dWEN  in  1  data write request
- daddr  in  32  data word address
- dstore  in  32  write data
- dwait  out  1  0 only in the cycle the data access completes
- dload  out  32  read data, valid when dwait==0 after dREN
- ramREN  out  1  RAM read strobe
- ramWEN  out  1  RAM write strobe
- ramaddr  out  32  RAM address
- ramstore  out  32  RAM write data
- ramload  in  32  RAM read data
- ramstate  in  2  FREE=0, BUSY=1, ACCESS=2, ERROR=3
- err  out  1  one-cycle pulse on RAM ERROR or timeout

Behaviour:
- Reset: when RST is sampled high, state=IDLE, timeout counter=0, starve counter=0. Outputs: iwait=1, dwait=1, iload=0, dload=0, ramREN=0, ramWEN=0, ramaddr=0, ramstore=0, err=0. Reset mid-access aborts the access with no completion.
- States: IDLE, IFETCH, DREAD, DWRITE.
- IDLE: RAM strobes are 0 and both waits are 1.
  - Grant priority: dWEN, then dREN, then iREN.
  - Exception: if iREN=1 and starve counter==STARVE_LIMIT, grant IFETCH.
  - dREN and dWEN both high: treat as write.
- Active state, RAM side:
  - IFETCH drives ramREN=1, ramaddr=iaddr.
  - DREAD drives ramREN=1, ramaddr=daddr.
  - DWRITE drives ramWEN=1, ramaddr=daddr, ramstore=dstore.
  - Address and data are taken live from the requester inputs each cycle, not latched.
- Active state, completion: when ramstate==ACCESS, in that same cycle (combinationally):
  - The served requester's wait=0.
  - For reads, iload or dload equals ramload.
  - Next state is IDLE.
  - At all other times iload=0 and dload=0.
- Minimum latency: request seen in IDLE at cycle N, state active at N+1, earliest wait=0 at N+1. There is always at least one IDLE cycle between accesses.
- Abort, requester drops: if the served request is deasserted in an active state, return to IDLE next cycle. Wait stays 1, no err.
- Abort, ERROR: if ramstate==ERROR, err=1 that cycle and return to IDLE. Wait stays 1. The requester re-arbitrates if its request is still held.
- Abort, timeout: the timeout counter increments each active cycle without ACCESS and clears on entering IDLE. When it reaches TIMEOUT-1 without ACCESS, err=1 and return to IDLE.
- Starve counter:
  - Increments on each data grant while iREN=1.
  - Clears on any instruction grant, or on a data grant with iREN=0.
  - Saturates at STARVE_LIMIT.
- Waits are only lowered by a genuine ACCESS completion, never by abort or reset.

Test Plan:
1. Reset held 2 cycles, then released with no requests -> iwait=1, dwait=1, ramREN=0, ramWEN=0, err=0 for 10 cycles.
2. iREN=1, iaddr=0x40, RAM returns ACCESS after 3 BUSY cycles with ramload=0xDEADBEEF -> ramREN=1, ramaddr=0x40 for 4 cycles; iwait=0 and iload=0xDEADBEEF in exactly the ACCESS cycle only.
3. dWEN=1 (daddr=0x80, dstore=0x1234) and iREN=1 raised in the same cycle, RAM latency 1 -> write is served first (ramWEN=1, ramstore=0x1234), dwait=0; after one IDLE cycle the instruction fetch is served.
4. iREN held high while dREN is re-asserted continuously, RAM latency 1, STARVE_LIMIT=4 -> exactly 4 data grants, then one IFETCH grant, then data grants resume.
5. dREN=1 with ramstate held BUSY, TIMEOUT=64 -> err pulses high for exactly 1 cycle at the 64th active cycle, dwait stays 1, state returns to IDLE and re-grants DREAD.
6. ramstate=ERROR during IFETCH, then RST asserted mid-way through a subsequent DREAD -> err=1 for one cycle with iwait=1; after the reset cycle all outputs are at reset values and no completion occurs.
